lifo_arbiter: RTL and testbench
===============================

Name: lifo_arbiter

Overview:
- Shares one lifo instance between N_REQ requesters; one push or one pop reaches the LIFO per cycle.
- Round-robin arbitration, gated by the LIFO's full/empty flags.
- Sequences the LIFO's synchronous reset: once after power-up reset, and on a flush request.
- Sits between client logic and the lifo; its LIFO-side ports connect 1:1 to lifo ports.

Parameters:
- DWIDTH, 16, data width; must match the lifo.
- N_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(N_REQ), requester index width (derived, not overridden).

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- push_i  in  N_REQ  per-requester push request
- pop_i  in  N_REQ  per-requester pop request
- wdata_i  in  N_REQ*DWIDTH  push data; requester k uses slice [k*DWIDTH +: DWIDTH]
- gnt_o  out  N_REQ  one-hot grant, combinational, same cycle as the request
- rvalid_o  out  N_REQ  one-hot; pop data valid for that requester
- rdata_o  out  DWIDTH  pop data, shared by all requesters
- flush_i  in  1  level request to empty the LIFO
- busy_o  out  1  high while the block is in INIT, FLUSH or SETTLE
- lifo_srst_o  out  1  to lifo srst_i
- lifo_wrreq_o  out  1  to lifo wrreq_i
- lifo_data_o  out  DWIDTH  to lifo data_i
- lifo_rdreq_o  out  1  to lifo rdreq_i
- lifo_q_i  in  DWIDTH  from lifo q_o; valid 1 cycle after rdreq
- lifo_full_i  in  1  from lifo full_o
- lifo_empty_i  in  1  from lifo empty_o

Behaviour:
- Reset (arst_n_i low, asynchronous):
  - state = INIT, rr_ptr = 0, pending tag cleared.
  - rvalid_o = 0, rdata_o = 0, lifo_srst_o = 1.
  - gnt_o, wrreq and rdreq all 0.
- State machine:
  - INIT: lifo_srst_o = 1 for exactly 1 cycle, then go to SETTLE.
  - SETTLE: 1 idle cycle with no grants, then go to ARB.
  - ARB: normal arbitration. If flush_i is high at a clock edge in ARB, go to FLUSH.
  - FLUSH: lifo_srst_o = 1 for 1 cycle, then go to SETTLE.
  - SETTLE returns to FLUSH instead of ARB if flush_i is still high.
- Request rules:
  - A requester holds push_i or pop_i and its wdata until it sees gnt_o[k].
  - push_i and pop_i high together on one requester is illegal; it is treated as a push.
- Eligibility (ARB state only):
  - Requester k is eligible if it requests a push and lifo_full_i = 0, or requests a pop and lifo_empty_i = 0.
  - Ineligible requesters keep waiting and are never dropped.
- Arbitration:
  - The first eligible requester at or after rr_ptr, searching upward modulo N_REQ, is granted.
  - After a grant, rr_ptr = granted index + 1 (mod N_REQ).
  - rr_ptr is unchanged when nothing is granted.
- LIFO drive:
  - Push grant: lifo_wrreq_o = 1 and lifo_data_o = wdata_i of the granted requester, same cycle.
  - Pop grant: lifo_rdreq_o = 1, same cycle.
  - With no grant, lifo_data_o = 0.
  - lifo_wrreq_o and lifo_rdreq_o are never high together.
- Pop return:
  - The granted index is registered.
  - In the next cycle: rvalid_o[idx] = 1 and rdata_o = lifo_q_i, passed through combinationally.
  - Back-to-back pops are allowed; each returns exactly 1 cycle after its grant.
- Flush:
  - No grants from the cycle FLUSH is entered until ARB is re-entered.
  - A pop granted in the last ARB cycle still returns its rvalid on the FLUSH cycle.
  - Pending requests survive the flush.
- Full/empty:
  - The flags are sampled combinationally each cycle.
  - A pop against a LIFO that becomes empty after a prior grant waits.
- busy_o = (state != ARB).

Optional Feature:
- Macro: LIFO_ARBITER_STATS_EN.
- When defined:
  - Extra output stat_o, N_REQ*16 bits: per-requester 16-bit saturating counts of granted operations.
  - Extra output wait_max_o, 16 bits: longest consecutive stall of any requested-but-ungranted requester; saturates.
  - Both clear on arst_n_i and on entry to FLUSH.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package lifo_arbiter_pkg holds:
  - enum arb_state_t {INIT, SETTLE, ARB, FLUSH};
  - typedef op_t {OP_NONE, OP_PUSH, OP_POP};
  - function rr_pick(req_vec, ptr) returning a one-hot grant.
- Sub-module lifo_rr_picker: combinational round-robin picker (req vector, pointer in; one-hot grant and index out), reused by other shared resources.

Test Plan:
- Release reset -> lifo_srst_o = 1 for exactly 1 cycle, busy_o high 2 cycles, first grant no earlier than cycle 3.
- All 4 requesters push continuously, LIFO empty, rr_ptr = 0 -> grants 0,1,2,3,0 on consecutive cycles; usedw increments 1 per cycle.
- Requester 2 pushes 0xA5A5 then pops -> rvalid_o[2] 1 cycle after the pop grant with rdata_o = 0xA5A5; no other rvalid bit set.
- LIFO full with requester 0 pushing and requester 1 popping -> only requester 1 is granted; requester 0 is granted the next cycle (full deasserted).
- Pop requested while the LIFO is empty -> no grant, rdreq_o stays 0; a push from requester 3 is granted meanwhile, then the pop is granted and returns requester 3's data.
- flush_i pulsed with 5 entries stored and requests pending -> lifo_srst_o pulses once, no grants for 2 cycles, LIFO empty after, pending pushes granted afterwards.

Source files
------------

// File: rtl/lifo_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the lifo arbiter.
package lifo_arbiter_pkg;

  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_IDX_W = 3;
  localparam int unsigned STAT_W    = 16;

  typedef enum logic [1:0] {INIT, SETTLE, ARB, FLUSH} arb_state_t;
  typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP} op_t;

  // First set bit of req_vec at or after ptr, wrapping modulo n; one-hot result.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0]   req_vec,
                                                 input logic [MAX_IDX_W-1:0] ptr,
                                                 input int unsigned          n);
    logic [MAX_REQ-1:0]   gnt;
    logic [MAX_IDX_W-1:0] idx;
    gnt = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = MAX_IDX_W'((32'(ptr) + i) % n);
      if ((i < n) && (gnt == '0) && req_vec[idx]) begin
        gnt[idx] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/lifo_arbiter_picker.sv
// Combinational round-robin picker: one-hot grant and its index for a request vector.
module lifo_rr_picker
  import lifo_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [MAX_REQ-1:0] w_gnt_full;
  logic               w_unused;

  assign w_gnt_full = rr_pick(MAX_REQ'(req_i), MAX_IDX_W'(ptr_i), N_REQ);
  assign gnt_o      = w_gnt_full[N_REQ-1:0];
  assign any_o      = |gnt_o;
  // Bits above N_REQ are always zero from rr_pick.
  assign w_unused   = ^w_gnt_full;

  always_comb begin
    idx_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_o[k]) idx_o = IDX_W'(k);
    end
  end

endmodule

// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one lifo between N_REQ push/pop clients and sequencing its
// synchronous reset. Optional grant/stall statistics under LIFO_ARBITER_STATS_EN.
module lifo_arbiter
  import lifo_arbiter_pkg::*;
#(
  parameter  int unsigned DWIDTH = 16,
  parameter  int unsigned N_REQ  = 4,
  localparam int unsigned IDX_W  = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  input  logic [N_REQ-1:0]        push_i,
  input  logic [N_REQ-1:0]        pop_i,
  input  logic [N_REQ*DWIDTH-1:0] wdata_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        rvalid_o,
  output logic [DWIDTH-1:0]       rdata_o,
  input  logic                    flush_i,
  output logic                    busy_o,
  output logic                    lifo_srst_o,
  output logic                    lifo_wrreq_o,
  output logic [DWIDTH-1:0]       lifo_data_o,
  output logic                    lifo_rdreq_o,
  input  logic [DWIDTH-1:0]       lifo_q_i,
  input  logic                    lifo_full_i,
  input  logic                    lifo_empty_i
`ifdef LIFO_ARBITER_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] stat_o,
  output logic [STAT_W-1:0]       wait_max_o
`endif
);

  arb_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic             r_pop_pend;
  logic [IDX_W-1:0] r_pop_idx;
  logic             w_arb_en;
  op_t              w_op [N_REQ];
  op_t              w_gnt_op;
  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_gnt;
  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_gnt_any;

  // Decode each requester; a simultaneous push and pop counts as a push.
  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_op[k] = OP_NONE;
      if (push_i[k]) begin
        w_op[k] = OP_PUSH;
      end else if (pop_i[k]) begin
        w_op[k] = OP_POP;
      end
      w_elig[k] = w_arb_en &&
                  (((w_op[k] == OP_PUSH) && !lifo_full_i) ||
                   ((w_op[k] == OP_POP)  && !lifo_empty_i));
    end
  end

  lifo_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i (w_elig),
    .ptr_i (r_rr_ptr),
    .gnt_o (w_gnt),
    .idx_o (w_gnt_idx),
    .any_o (w_gnt_any)
  );

  always_comb begin
    w_gnt_op    = OP_NONE;
    lifo_data_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_gnt[k]) begin
        w_gnt_op = w_op[k];
        if (w_op[k] == OP_PUSH) lifo_data_o = wdata_i[k*DWIDTH +: DWIDTH];
      end
    end
  end

  assign gnt_o        = w_gnt;
  assign lifo_wrreq_o = (w_gnt_op == OP_PUSH);
  assign lifo_rdreq_o = (w_gnt_op == OP_POP);

  always_comb begin
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_gnt_any) begin
      w_rr_ptr_nxt = (w_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state    <= INIT;
      r_rr_ptr   <= '0;
      r_pop_pend <= 1'b0;
      r_pop_idx  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_pop_pend <= lifo_rdreq_o;
      r_pop_idx  <= w_gnt_idx;
    end
  end

  // Lifo reset sequencing: reset pulse, one quiet cycle, then arbitration.
  always_comb begin
    w_state_nxt = r_state;
    lifo_srst_o = 1'b0;
    busy_o      = 1'b1;
    w_arb_en    = 1'b0;
    case (r_state)
      INIT: begin
        lifo_srst_o = 1'b1;
        w_state_nxt = SETTLE;
      end
      SETTLE: begin
        w_state_nxt = flush_i ? FLUSH : ARB;
      end
      ARB: begin
        busy_o   = 1'b0;
        w_arb_en = 1'b1;
        if (flush_i) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        lifo_srst_o = 1'b1;
        w_state_nxt = SETTLE;
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

  // Pop data is steered to the requester granted one cycle earlier.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (r_pop_pend) begin
      rvalid_o[r_pop_idx] = 1'b1;
      rdata_o             = lifo_q_i;
    end
  end

`ifdef LIFO_ARBITER_STATS_EN
  logic [STAT_W-1:0] r_stat [N_REQ];
  logic [STAT_W-1:0] r_wait [N_REQ];
  logic [STAT_W-1:0] r_wait_max;
  logic [STAT_W-1:0] w_wait_peak;
  logic              w_flush_entry;

  assign w_flush_entry = (r_state != FLUSH) && (w_state_nxt == FLUSH);

  always_comb begin
    w_wait_peak = r_wait_max;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (r_wait[k] > w_wait_peak) w_wait_peak = r_wait[k];
    end
  end

  // Saturating grant counts and per-requester stall run lengths.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        r_stat[k] <= '0;
        r_wait[k] <= '0;
      end
      r_wait_max <= '0;
    end else if (w_flush_entry) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        r_stat[k] <= '0;
        r_wait[k] <= '0;
      end
      r_wait_max <= '0;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (w_gnt[k] && (r_stat[k] != '1)) r_stat[k] <= r_stat[k] + STAT_W'(1);
        if (w_gnt[k] || !(push_i[k] || pop_i[k])) begin
          r_wait[k] <= '0;
        end else if (r_wait[k] != '1) begin
          r_wait[k] <= r_wait[k] + STAT_W'(1);
        end
      end
      r_wait_max <= w_wait_peak;
    end
  end

  always_comb begin
    stat_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      stat_o[k*STAT_W +: STAT_W] = r_stat[k];
    end
  end

  assign wait_max_o = r_wait_max;
`endif

endmodule

// File: tb/tb_lifo_arbiter.sv
// Self-checking bench for lifo_arbiter: behavioural lifo device, stack-based reference
// model with a scoreboard for pop returns, directed scenarios plus randomized traffic.
module tb_lifo_arbiter;

  localparam int unsigned DW    = 16;
  localparam int unsigned NR    = 4;
  localparam int          DEPTH = 8;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic [NR-1:0]    push = '0, pop = '0;
  logic [NR*DW-1:0] wdata = '0;
  logic             flush = 1'b0;
  logic [NR-1:0]    gnt, rvalid;
  logic [DW-1:0]    rdata, l_data, l_q;
  logic             busy, l_srst, l_wr, l_rd, l_full, l_empty;

  always #5 clk = ~clk;

  lifo_arbiter #(.DWIDTH(DW), .N_REQ(NR)) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .push_i       (push),
    .pop_i        (pop),
    .wdata_i      (wdata),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .flush_i      (flush),
    .busy_o       (busy),
    .lifo_srst_o  (l_srst),
    .lifo_wrreq_o (l_wr),
    .lifo_data_o  (l_data),
    .lifo_rdreq_o (l_rd),
    .lifo_q_i     (l_q),
    .lifo_full_i  (l_full),
    .lifo_empty_i (l_empty)
  );

  // Lifo device: sync reset, q registered one cycle after rdreq.
  logic [DW-1:0] mem [DEPTH];
  int            dcnt = 0;
  logic [DW-1:0] dq = '0;
  always @(posedge clk) begin
    if (l_srst) begin
      dcnt <= 0;
    end else if (l_wr && dcnt < DEPTH) begin
      mem[3'(dcnt)] <= l_data;
      dcnt <= dcnt + 1;
    end else if (l_rd && dcnt > 0) begin
      dq   <= mem[3'(dcnt - 1)];
      dcnt <= dcnt - 1;
    end
  end
  assign l_q     = dq;
  assign l_full  = (dcnt == DEPTH);
  assign l_empty = (dcnt == 0);

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  int            total = 0, bad = 0, cyc = 0;
  bit            model_on = 1'b0;
  bit            m_srst = 1'b1, m_settle = 1'b0, m_arb = 1'b0;
  int            m_ptr = 0;
  logic [DW-1:0] m_stack[$];
  exp_t          sb[$];
  logic [NR-1:0] gnt_seen = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: phase flags, round-robin pointer and a stack of stored words.
  always @(negedge clk) begin : model_blk
    logic [NR-1:0] e_gnt;
    logic [DW-1:0] e_data;
    int            e_k, kk;
    bit            e_push;
    exp_t          ne;
    if (model_on) begin
      e_gnt = '0; e_data = '0; e_k = -1; e_push = 1'b0;
      if (m_arb) begin
        for (int j = 0; j < NR; j++) begin
          kk = (m_ptr + j) % NR;
          if (e_k < 0) begin
            if (push[kk] && m_stack.size() < DEPTH) begin
              e_k = kk; e_push = 1'b1;
            end else if (!push[kk] && pop[kk] && m_stack.size() > 0) begin
              e_k = kk; e_push = 1'b0;
            end
          end
        end
      end
      if (e_k >= 0) begin
        e_gnt[e_k] = 1'b1;
        if (e_push) e_data = wdata[e_k*DW +: DW];
      end
      chk("gnt", 64'(gnt), 64'(e_gnt));
      chk("srst", 64'(l_srst), 64'(m_srst));
      chk("busy", 64'(busy), 64'(!m_arb));
      chk("wrreq", 64'(l_wr), 64'(e_k >= 0 && e_push));
      chk("rdreq", 64'(l_rd), 64'(e_k >= 0 && !e_push));
      chk("lifo_data", 64'(l_data), 64'(e_data));
      gnt_seen = gnt;
      if (e_k >= 0) begin
        m_ptr = (e_k + 1) % NR;
        if (e_push) begin
          m_stack.push_back(wdata[e_k*DW +: DW]);
        end else begin
          ne.idx = e_k; ne.data = m_stack.pop_back(); ne.due = cyc + 1;
          sb.push_back(ne);
        end
      end
      if (m_srst) begin
        m_stack.delete();
        m_srst = 1'b0; m_settle = 1'b1;
      end else if (m_settle) begin
        m_settle = 1'b0;
        if (flush) m_srst = 1'b1; else m_arb = 1'b1;
      end else if (flush) begin
        m_arb = 1'b0; m_srst = 1'b1;
      end
    end
  end

  // Monitor: every rvalid must match the oldest expected pop return, exactly on time.
  always @(negedge clk) begin : monitor_blk
    exp_t e;
    if (model_on) begin
      if (rvalid !== '0) begin
        if (sb.size() == 0) begin
          chk("rvalid_unexpected", 64'(rvalid), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("rvalid", 64'(rvalid), 64'(NR'(1) << e.idx));
          chk("rdata", 64'(rdata), 64'(e.data));
          chk("rlatency", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("rvalid_missing", 64'(rvalid), 64'(NR'(1) << e.idx));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    push &= ~gnt_seen;
    pop  &= ~gnt_seen;
  endtask

  task automatic settle_reqs();
    int n;
    n = 0;
    while ((push | pop) != '0 && n < 100) begin
      tick();
      n++;
    end
    chk("reqs_granted", 64'(push | pop), 64'(0));
  endtask

  task automatic multi(input logic [NR-1:0] pm, input logic [NR-1:0] qm,
                       input bit fixed, input logic [DW-1:0] d);
    push = pm;
    pop  = qm;
    for (int k = 0; k < NR; k++) wdata[k*DW +: DW] = fixed ? d : DW'($urandom);
    settle_reqs();
  endtask

  task automatic flush_pulse(input int n);
    flush = 1'b1;
    repeat (n) tick();
    flush = 1'b0;
    repeat (3) tick();
  endtask

  task automatic rand_run(input int n, input int p_req, input int p_push,
                          input int p_both, input int p_flush);
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < NR; k++) begin
        if (!push[k] && !pop[k] && int'($urandom_range(99)) < p_req) begin
          if (int'($urandom_range(99)) < p_both) begin
            push[k] = 1'b1; pop[k] = 1'b1;
          end else if (int'($urandom_range(99)) < p_push) begin
            push[k] = 1'b1;
          end else begin
            pop[k] = 1'b1;
          end
          wdata[k*DW +: DW] = DW'($urandom);
        end
      end
      flush = (int'($urandom_range(99)) < p_flush);
      tick();
    end
    flush = 1'b0;
    push  = '0;
    pop   = '0;
    flush_pulse(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    push = '1;
    for (int k = 0; k < NR; k++) wdata[k*DW +: DW] = DW'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_srst", 64'(l_srst), 64'(1));
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_wrreq", 64'(l_wr), 64'(0));
    chk("rst_rdreq", 64'(l_rd), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));
    @(posedge clk); #1;
    arst_n   = 1'b1;
    model_on = 1'b1;

    settle_reqs();                        // startup sequence then grants 0,1,2,3
    multi(4'b1111, 4'b0000, 1'b0, '0);    // fills the lifo
    multi(4'b0001, 4'b0010, 1'b0, '0);    // full: pop first, push once space frees
    flush_pulse(1);
    multi(4'b0100, 4'b0000, 1'b1, 16'hA5A5);
    multi(4'b0000, 4'b0100, 1'b0, '0);
    flush_pulse(1);
    multi(4'b1000, 4'b0010, 1'b0, '0);    // pop on empty waits for requester 3's push
    flush_pulse(3);                       // flush held across SETTLE
    multi(4'b1111, 4'b0000, 1'b0, '0);
    multi(4'b0001, 4'b0000, 1'b0, '0);    // five entries stored
    push = 4'b0111;
    for (int k = 0; k < NR; k++) wdata[k*DW +: DW] = DW'($urandom);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle_reqs();                        // pending pushes survive the flush

    rand_run(12, 100, 100, 0, 0);
    rand_run(300, 60, 55, 5, 0);
    rand_run(300, 70, 50, 5, 4);
    rand_run(300, 90, 25, 10, 1);
    rand_run(200, 40, 80, 0, 2);

    repeat (4) tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
